// File: rtl/node_info_engine.sv
// Per-node routing state keeper: hop distance, energy class, CH role, TDMA slot and Q = energy/hops.
// Optional NODE_INFO_EMA_EN: Q becomes a running average of successive quotients.
module node_info_engine #(
  parameter int                    WORD_WIDTH = 16,
  parameter int                    FRAC_BITS  = 14,
  parameter logic [WORD_WIDTH-1:0] NODE_ID    = 'h000C,
  parameter int                    TS_WIDTH   = 8,
  parameter int                    MAX_HOPS   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_MNI,
  input  logic [2:0]            fPktType,
  input  logic [WORD_WIDTH-1:0] energy,
  input  logic [WORD_WIDTH-1:0] e_threshold,
  input  logic [WORD_WIDTH-1:0] hops,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [TS_WIDTH-1:0]   timeslot,
  output logic [WORD_WIDTH-1:0] myNodeID,
  output logic [WORD_WIDTH-1:0] hopsFromSink,
  output logic [WORD_WIDTH-1:0] myQValue,
  output logic                  role,
  output logic                  low_E,
  output logic [TS_WIDTH-1:0]   myTimeslot,
  output logic                  ts_valid,
  output logic                  busy,
  output logic                  q_valid,
  output logic                  drop
);
  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        hops_q, hops_d, q_q, q_d;
  logic [W-1:0]        dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic [W:0]          rem_sh;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                role_q, role_d, lowe_q, lowe_d, tsv_q, tsv_d;
  logic                lock_q, lock_d, qv_q, qv_d, drop_q, drop_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
`ifdef NODE_INFO_EMA_EN
  logic                qinit_q, qinit_d;
  logic [W:0]          ema_sum;
  assign ema_sum = {1'b0, q_q} + {1'b0, quo_q};
`endif

  always_comb begin
    state_d = state_q;
    hops_d  = hops_q;
    q_d     = q_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    role_d  = role_q;
    lowe_d  = lowe_q;
    tsv_d   = tsv_q;
    ts_d    = ts_q;
    lock_d  = lock_q;
    qv_d    = 1'b0;
    drop_d  = 1'b0;
`ifdef NODE_INFO_EMA_EN
    qinit_d = qinit_q;
`endif
    rem_sh  = {rem_q, dvd_q[W-1]};

    case (state_q)
      DIV: begin
        // Divisor 0 never fails the compare, so hops=0 yields all ones naturally
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = rem_sh[W-1:0] - dvs_q;
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        dvd_d = {dvd_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) state_d = DONE;
      end
      DONE: begin
`ifdef NODE_INFO_EMA_EN
        q_d     = qinit_q ? W'(ema_sum >> 1) : quo_q;
        qinit_d = 1'b1;
`else
        q_d     = quo_q;
`endif
        qv_d    = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase

    if (en_MNI) begin
      case (fPktType)
        3'b000: begin
          if (!lock_q && state_q == IDLE) begin
            hops_d  = (hops > W'(MAX_HOPS)) ? W'(MAX_HOPS) : hops;
            lowe_d  = (energy < e_threshold);
            role_d  = 1'b0;
            tsv_d   = 1'b0;
            lock_d  = 1'b1;
            dvd_d   = energy;
            dvs_d   = hops;
            quo_d   = '0;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV;
          end else begin
            drop_d = 1'b1;
          end
        end
        3'b001: if (destinationID == NODE_ID) role_d = 1'b1;
        3'b100: begin
          if (!role_q && destinationID == NODE_ID) begin
            ts_d   = timeslot;
            tsv_d  = 1'b1;
            lock_d = 1'b0;
          end
        end
        3'b101: lock_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hops_q  <= '0;
      q_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      role_q  <= 1'b0;
      lowe_q  <= 1'b0;
      tsv_q   <= 1'b0;
      ts_q    <= '0;
      lock_q  <= 1'b0;
      qv_q    <= 1'b0;
      drop_q  <= 1'b0;
`ifdef NODE_INFO_EMA_EN
      qinit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hops_q  <= hops_d;
      q_q     <= q_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      role_q  <= role_d;
      lowe_q  <= lowe_d;
      tsv_q   <= tsv_d;
      ts_q    <= ts_d;
      lock_q  <= lock_d;
      qv_q    <= qv_d;
      drop_q  <= drop_d;
`ifdef NODE_INFO_EMA_EN
      qinit_q <= qinit_d;
`endif
    end
  end

  assign myNodeID     = NODE_ID;
  assign hopsFromSink = hops_q;
  assign myQValue     = q_q;
  assign role         = role_q;
  assign low_E        = lowe_q;
  assign myTimeslot   = ts_q;
  assign ts_valid     = tsv_q;
  assign busy         = (state_q != IDLE);
  assign q_valid      = qv_q;
  assign drop         = drop_q;
endmodule

// File: tb/tb_node_info_engine.sv
// Bench for node_info_engine: directed vector table, latency/reset-abort sequences, random run vs reference model.
module tb_node_info_engine;
  localparam logic [15:0] NID = 16'h000C;
`ifdef NODE_INFO_EMA_EN
  localparam logic [15:0] Q2 = 16'h5000;
  localparam logic [15:0] Q3 = 16'hA7FF;
`else
  localparam logic [15:0] Q2 = 16'h2000;
  localparam logic [15:0] Q3 = 16'hFFFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_MNI;
  logic [2:0] fPktType;
  logic [15:0] energy, e_threshold, hops, destinationID;
  logic [7:0] timeslot;
  logic [15:0] myNodeID, hopsFromSink, myQValue;
  logic role, low_E, ts_valid, busy, q_valid, drop;
  logic [7:0] myTimeslot;

  node_info_engine dut (
    .clk(clk), .rst(rst), .en_MNI(en_MNI), .fPktType(fPktType), .energy(energy),
    .e_threshold(e_threshold), .hops(hops), .destinationID(destinationID), .timeslot(timeslot),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue), .role(role),
    .low_E(low_E), .myTimeslot(myTimeslot), .ts_valid(ts_valid), .busy(busy),
    .q_valid(q_valid), .drop(drop)
  );

  int n_tests = 0, n_fail = 0;
  int qv_cnt, drop_cnt;

  // reference model: pending division is a countdown to the result cycle
  logic [15:0] m_hops, m_q, m_pend;
  logic [7:0]  m_ts;
  logic m_role, m_lowE, m_tsv, m_lock, m_qinit, m_qv, m_drop;
  int m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic [2:0] t, input logic [15:0] e,
                            input logic [15:0] thr, input logic [15:0] h, input logic [15:0] d,
                            input logic [7:0] s);
    bit was_busy;
    if (r) begin
      m_hops = 0; m_q = 0; m_pend = 0; m_ts = 0; m_role = 0; m_lowE = 0; m_tsv = 0;
      m_lock = 0; m_qinit = 0; m_qv = 0; m_drop = 0; m_cnt = 0;
      return;
    end
    m_qv = 0; m_drop = 0;
    was_busy = (m_cnt > 0);
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
`ifdef NODE_INFO_EMA_EN
        m_q = m_qinit ? 16'((int'(m_q) + int'(m_pend)) / 2) : m_pend;
`else
        m_q = m_pend;
`endif
        m_qinit = 1; m_qv = 1;
      end
    end
    if (en) begin
      case (t)
        3'd0: if (!m_lock && !was_busy) begin
          m_hops = (h > 255) ? 16'd255 : h;
          m_lowE = (e < thr);
          m_role = 0; m_tsv = 0; m_lock = 1;
          m_pend = (h == 0) ? 16'hFFFF : e / h;
          m_cnt  = 17;
        end else m_drop = 1;
        3'd1: if (d == NID) m_role = 1;
        3'd4: if (!m_role && d == NID) begin m_ts = s; m_tsv = 1; m_lock = 0; end
        3'd5: m_lock = 0;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic [2:0] t, input logic [15:0] e,
                     input logic [15:0] thr, input logic [15:0] h, input logic [15:0] d,
                     input logic [7:0] s);
    rst = r; en_MNI = en; fPktType = t; energy = e; e_threshold = thr; hops = h;
    destinationID = d; timeslot = s;
    @(posedge clk);
    model_step(r, en, t, e, thr, h, d, s);
    #1;
    chk("model", {18'd0, hopsFromSink, myQValue, role, low_E, myTimeslot, ts_valid, busy, q_valid, drop},
        {18'd0, m_hops, m_q, m_role, m_lowE, m_ts, m_tsv, (m_cnt > 0), m_qv, m_drop});
    if (q_valid) qv_cnt++;
    if (drop) drop_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd3, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0);
  endtask

  typedef struct {
    logic [2:0] typ; logic [15:0] e, thr, h, dest; logic [7:0] ts; int wait_n;
    logic [15:0] x_hops, x_q; logic x_role, x_lowE; logic [7:0] x_ts; logic x_tsv;
    int x_qv, x_drop;
  } vec_t;
  vec_t vt[10];

  initial begin
    int lat;
    vt[0] = '{3'd0, 16'h8000, 16'h3333, 16'd1, 16'h0,  8'd0, 18, 16'd1, 16'h8000, 1'b0, 1'b0, 8'd0, 1'b0, 1, 0};
    vt[1] = '{3'd0, 16'h7FC0, 16'h3333, 16'd2, 16'h0,  8'd0, 18, 16'd1, 16'h8000, 1'b0, 1'b0, 8'd0, 1'b0, 0, 1};
    vt[2] = '{3'd1, 16'h0,    16'h0,    16'd0, 16'h20, 8'd0, 1,  16'd1, 16'h8000, 1'b0, 1'b0, 8'd0, 1'b0, 0, 0};
    vt[3] = '{3'd2, 16'h0,    16'h0,    16'd0, NID,    8'd0, 1,  16'd1, 16'h8000, 1'b0, 1'b0, 8'd0, 1'b0, 0, 0};
    vt[4] = '{3'd1, 16'h0,    16'h0,    16'd0, NID,    8'd0, 1,  16'd1, 16'h8000, 1'b1, 1'b0, 8'd0, 1'b0, 0, 0};
    vt[5] = '{3'd4, 16'h0,    16'h0,    16'd0, NID,    8'd4, 1,  16'd1, 16'h8000, 1'b1, 1'b0, 8'd0, 1'b0, 0, 0};
    vt[6] = '{3'd5, 16'h0,    16'h0,    16'd0, 16'h0,  8'd0, 1,  16'd1, 16'h8000, 1'b1, 1'b0, 8'd0, 1'b0, 0, 0};
    vt[7] = '{3'd0, 16'h6000, 16'h3333, 16'd3, 16'h0,  8'd0, 18, 16'd3, Q2,       1'b0, 1'b0, 8'd0, 1'b0, 1, 0};
    vt[8] = '{3'd4, 16'h0,    16'h0,    16'd0, NID,    8'd5, 1,  16'd3, Q2,       1'b0, 1'b0, 8'd5, 1'b1, 0, 0};
    vt[9] = '{3'd0, 16'h3000, 16'h3333, 16'd0, 16'h0,  8'd0, 18, 16'd0, Q3,       1'b0, 1'b1, 8'd5, 1'b0, 1, 0};

    qv_cnt = 0; drop_cnt = 0;
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    chk("reset_outs", {hopsFromSink, myQValue, myTimeslot, role, low_E, ts_valid, busy, q_valid, drop}, 54'd0);
    chk("node_id", myNodeID, NID);

    for (int i = 0; i < 10; i++) begin
      qv_cnt = 0; drop_cnt = 0;
      cyc(1'b0, 1'b1, vt[i].typ, vt[i].e, vt[i].thr, vt[i].h, vt[i].dest, vt[i].ts);
      idle(vt[i].wait_n);
      chk($sformatf("vec%0d_hops", i), hopsFromSink, vt[i].x_hops);
      chk($sformatf("vec%0d_q", i), myQValue, vt[i].x_q);
      chk($sformatf("vec%0d_flags", i), {role, low_E, ts_valid}, {vt[i].x_role, vt[i].x_lowE, vt[i].x_tsv});
      chk($sformatf("vec%0d_ts", i), myTimeslot, vt[i].x_ts);
      chk($sformatf("vec%0d_qv", i), qv_cnt, vt[i].x_qv);
      chk($sformatf("vec%0d_drop", i), drop_cnt, vt[i].x_drop);
    end

    // HB latency: busy next cycle, q_valid on the 17th edge, busy already low then
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    cyc(1'b0, 1'b1, 3'd0, 16'h9000, 16'h1000, 16'd3, 16'h0, 8'h0);
    chk("busy_rise", busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      if (q_valid) begin lat = k; break; end
    end
    chk("q_latency", lat, 17);
    chk("busy_fall", busy, 1'b0);
    chk("q_lat_val", myQValue, 16'h3000);

    // reset on DIV cycle 8 aborts the division
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    cyc(1'b0, 1'b1, 3'd0, 16'h8000, 16'h1000, 16'd1, 16'h0, 8'h0);
    idle(7);
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_q", myQValue, 16'h0);
    qv_cnt = 0;
    idle(20);
    chk("abort_no_qv", qv_cnt, 0);
    chk("abort_q_hold", myQValue, 16'h0);

    // random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] hv;
      hv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
          16'($urandom), 16'($urandom), hv,
          ($urandom_range(0, 1) == 0) ? NID : 16'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
